cpu_serial_frame_loader: RTL and testbench
==========================================

// Module: cpu_serial_frame_loader
// PURPOSE
//  Parametrised serial front end for the CPU datapath. It shifts one frame of
//  operand A, operand B and opcode from a bit-serial pin into staging
//  registers. Accepted bits are qualified by a valid strobe.
//  On completion it commits all three fields atomically to the output
//  registers, then holds frame_valid_o until the consumer acknowledges it.
//  Adds programmable bit order, an inter-bit timeout, abort and a frame counter.
// PARAMETERS
//  DATA_W       8    width of operand A and operand B fields (>=2)
//  OP_W         4    width of opcode field (>=2)
//  LSB_FIRST    0    0: MSB transmitted first; 1: LSB transmitted first
//  TIMEOUT_CYC  255  idle cycles tolerated between accepted bits; 0 disables
// PORTS
//  clk_i          in   1       clock, all logic on rising edge
//  rst_ni         in   1       synchronous active-low reset
//  start_i        in   1       begin a frame (sampled only in IDLE)
//  bit_i          in   1       serial data bit
//  bit_valid_i    in   1       bit_i is consumed on this edge when in a LOAD state
//  abort_i        in   1       abandon current frame, return to IDLE
//  ack_i          in   1       consumer has taken the committed frame
//  reg_a_o        out  DATA_W  committed operand A
//  reg_b_o        out  DATA_W  committed operand B
//  reg_op_o       out  OP_W    committed opcode
//  frame_valid_o  out  1       committed frame awaiting ack (level)
//  busy_o         out  1       1 in LOAD_A/LOAD_B/LOAD_OP
//  err_timeout_o  out  1       one-cycle pulse on timeout abort
//  frame_cnt_o    out  8       count of committed frames, wraps 255->0
// BEHAVIOUR
//  Reset (rst_ni=0 at an edge): state=IDLE; all outputs, staging regs and counters are 0.
//  States: IDLE, LOAD_A, LOAD_B, LOAD_OP, HOLD.
//  IDLE: start_i=1 -> LOAD_A. bit_valid_i is ignored, including in the start cycle.
//   The bit counter and timeout counter are cleared.
//  LOAD_x: when bit_valid_i=1, shift bit_i into staging field x and increment the bit counter.
//   MSB-first shift is {s[W-2:0],bit_i}; LSB-first shift is {bit_i,s[W-1:1]}.
//   The bit accepted with count==W-1 clears the counter and advances the state:
//   LOAD_A->LOAD_B, LOAD_B->LOAD_OP, LOAD_OP->HOLD.
//   There are no dead cycles between fields.
//  Commit: on the edge that accepts the last opcode bit, copy staging A/B/OP to the
//   outputs, set frame_valid_o and increment frame_cnt_o. Outputs are visible
//   in the next cycle.
//  HOLD: frame_valid_o=1 and outputs are stable. ack_i=1 -> IDLE and clears frame_valid_o
//   on the same edge. start_i in HOLD is ignored; it must be re-asserted in IDLE.
//  Timeout (TIMEOUT_CYC>0): the counter increments on each LOAD cycle with bit_valid_i=0
//   and clears on every accepted bit. Reaching TIMEOUT_CYC -> IDLE with
//   err_timeout_o=1 for exactly one cycle.
//  Abort: abort_i=1 in any LOAD state -> IDLE with no error; in IDLE/HOLD it has no effect.
//  Priority within a LOAD cycle: abort_i > timeout > bit acceptance.
//  An abandoned frame never touches reg_*_o, frame_valid_o or frame_cnt_o.
//  Staging contents after an abort or timeout are don't-care.
//  busy_o and frame_valid_o are registered state decodes with no combinational input paths.
// TESTING
//  1 A=0xA5,B=0x3C,OP=0x9 MSB-first, bit_valid every cycle -> frame_valid_o high the cycle
//    after the 20th bit, outputs A5/3C/9, frame_cnt_o=1, held until ack_i.
//  2 Same frame with bit_valid every 3rd cycle, TIMEOUT_CYC=16 -> identical result, no error.
//  3 Stall 16 cycles after the 5th bit of B (TIMEOUT_CYC=16) -> err_timeout_o pulses once,
//    IDLE, prior frame outputs and frame_cnt_o unchanged.
//  4 abort_i with bit_valid_i in the same cycle mid-opcode -> IDLE, no error, outputs
//    unchanged; a following full frame commits normally.
//  5 rst_ni=0 for one edge mid LOAD_B, and separately in HOLD -> every output 0 next cycle,
//    state IDLE.
//  6 LSB_FIRST=1, DATA_W=16, OP_W=6: A=0x1234,B=0xBEEF,OP=0x2A sent LSB first -> exact
//    values committed; 256 frames wrap frame_cnt_o to 0.

Source files
------------

// File: rtl/cpu_serial_frame_loader.sv
// Bit-serial loader for one CPU frame (operand A, operand B, opcode) with atomic
// commit, programmable bit order, inter-bit timeout, abort and a frame counter.
module cpu_serial_frame_loader #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned OP_W        = 4,
    parameter int unsigned LSB_FIRST   = 0,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              bit_i,
    input  logic              bit_valid_i,
    input  logic              abort_i,
    input  logic              ack_i,
    output logic [DATA_W-1:0] reg_a_o,
    output logic [DATA_W-1:0] reg_b_o,
    output logic [OP_W-1:0]   reg_op_o,
    output logic              frame_valid_o,
    output logic              busy_o,
    output logic              err_timeout_o,
    output logic [7:0]        frame_cnt_o
);

    localparam int unsigned MAX_W    = (DATA_W > OP_W) ? DATA_W : OP_W;
    localparam int unsigned CNT_W    = $clog2(MAX_W);
    localparam int unsigned TMO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int unsigned TMO_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
    localparam logic        TMO_EN   = (TIMEOUT_CYC > 0);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] LOAD_A  = 3'd1;
    localparam logic [2:0] LOAD_B  = 3'd2;
    localparam logic [2:0] LOAD_OP = 3'd3;
    localparam logic [2:0] HOLD    = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic [TMO_W-1:0]  tmo_cnt_q;
    logic [DATA_W-1:0] stage_a_q, stage_b_q;
    logic [OP_W-1:0]   stage_op_q;
    logic              in_load, last_bit, tmo_hit, accept;

    function automatic logic [DATA_W-1:0] shift_d(input logic [DATA_W-1:0] s, input logic b);
        return (LSB_FIRST != 0) ? {b, s[DATA_W-1:1]} : {s[DATA_W-2:0], b};
    endfunction

    function automatic logic [OP_W-1:0] shift_op(input logic [OP_W-1:0] s, input logic b);
        return (LSB_FIRST != 0) ? {b, s[OP_W-1:1]} : {s[OP_W-2:0], b};
    endfunction

    // Next-state and per-cycle qualifiers; abort beats timeout beats bit acceptance.
    always_comb begin
        state_d  = state_q;
        in_load  = (state_q == LOAD_A) || (state_q == LOAD_B) || (state_q == LOAD_OP);
        last_bit = (state_q == LOAD_OP) ? (bit_cnt_q == CNT_W'(OP_W - 1))
                                        : (bit_cnt_q == CNT_W'(DATA_W - 1));
        tmo_hit  = TMO_EN && in_load && !bit_valid_i && (tmo_cnt_q == TMO_W'(TMO_LAST));
        accept   = in_load && bit_valid_i && !abort_i;
        case (state_q)
            IDLE:    if (start_i) state_d = LOAD_A;
            LOAD_A:  if (abort_i || tmo_hit) state_d = IDLE;
                     else if (accept && last_bit) state_d = LOAD_B;
            LOAD_B:  if (abort_i || tmo_hit) state_d = IDLE;
                     else if (accept && last_bit) state_d = LOAD_OP;
            LOAD_OP: if (abort_i || tmo_hit) state_d = IDLE;
                     else if (accept && last_bit) state_d = HOLD;
            HOLD:    if (ack_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            tmo_cnt_q     <= '0;
            stage_a_q     <= '0;
            stage_b_q     <= '0;
            stage_op_q    <= '0;
            reg_a_o       <= '0;
            reg_b_o       <= '0;
            reg_op_o      <= '0;
            frame_valid_o <= 1'b0;
            busy_o        <= 1'b0;
            err_timeout_o <= 1'b0;
            frame_cnt_o   <= '0;
        end else begin
            state_q       <= state_d;
            busy_o        <= (state_d == LOAD_A) || (state_d == LOAD_B) || (state_d == LOAD_OP);
            frame_valid_o <= (state_d == HOLD);
            err_timeout_o <= tmo_hit && !abort_i;
            if (state_q == IDLE) begin
                bit_cnt_q <= '0;
                tmo_cnt_q <= '0;
            end else if (accept) begin
                bit_cnt_q <= last_bit ? '0 : bit_cnt_q + CNT_W'(1);
                tmo_cnt_q <= '0;
                case (state_q)
                    LOAD_A:  stage_a_q  <= shift_d(stage_a_q, bit_i);
                    LOAD_B:  stage_b_q  <= shift_d(stage_b_q, bit_i);
                    default: stage_op_q <= shift_op(stage_op_q, bit_i);
                endcase
                // Commit the whole frame on the edge that takes the last opcode bit.
                if (state_q == LOAD_OP && last_bit) begin
                    reg_a_o     <= stage_a_q;
                    reg_b_o     <= stage_b_q;
                    reg_op_o    <= shift_op(stage_op_q, bit_i);
                    frame_cnt_o <= frame_cnt_o + 8'd1;
                end
            end else if (in_load && !bit_valid_i && TMO_EN) begin
                tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_cpu_serial_frame_loader.sv
// Randomized bench for cpu_serial_frame_loader: an 8/8/4 MSB-first instance and a
// 16/16/6 LSB-first instance, checked against a transaction-level frame model.
module tb_cpu_serial_frame_loader;

    localparam int TMO = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start [2];
    logic bitv  [2];
    logic valid [2];
    logic abort [2];
    logic ack   [2];

    logic [7:0]  a0, b0, cnt0, cnt1;
    logic [3:0]  op0;
    logic [15:0] a1, b1;
    logic [5:0]  op1;
    logic        fv0, fv1, busy0, busy1, err0, err1;

    cpu_serial_frame_loader #(.DATA_W(8), .OP_W(4), .LSB_FIRST(0), .TIMEOUT_CYC(TMO)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start[0]), .bit_i(bitv[0]),
        .bit_valid_i(valid[0]), .abort_i(abort[0]), .ack_i(ack[0]),
        .reg_a_o(a0), .reg_b_o(b0), .reg_op_o(op0), .frame_valid_o(fv0),
        .busy_o(busy0), .err_timeout_o(err0), .frame_cnt_o(cnt0));

    cpu_serial_frame_loader #(.DATA_W(16), .OP_W(6), .LSB_FIRST(1), .TIMEOUT_CYC(TMO)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start[1]), .bit_i(bitv[1]),
        .bit_valid_i(valid[1]), .abort_i(abort[1]), .ack_i(ack[1]),
        .reg_a_o(a1), .reg_b_o(b1), .reg_op_o(op1), .frame_valid_o(fv1),
        .busy_o(busy1), .err_timeout_o(err1), .frame_cnt_o(cnt1));

    int checks = 0;
    int errors = 0;

    // Expected committed frame per instance.
    logic [15:0] exp_a   [2];
    logic [15:0] exp_b   [2];
    logic [7:0]  exp_op  [2];
    logic [7:0]  exp_cnt [2];

    function automatic int dw_of(input int s); return s ? 16 : 8; endfunction
    function automatic int ow_of(input int s); return s ? 6 : 4; endfunction
    function automatic logic [31:0] obs_a(input int s);    return s ? 32'(a1) : 32'(a0); endfunction
    function automatic logic [31:0] obs_b(input int s);    return s ? 32'(b1) : 32'(b0); endfunction
    function automatic logic [31:0] obs_op(input int s);   return s ? 32'(op1) : 32'(op0); endfunction
    function automatic logic [31:0] obs_cnt(input int s);  return s ? 32'(cnt1) : 32'(cnt0); endfunction
    function automatic logic [31:0] obs_fv(input int s);   return s ? 32'(fv1) : 32'(fv0); endfunction
    function automatic logic [31:0] obs_busy(input int s); return s ? 32'(busy1) : 32'(busy0); endfunction
    function automatic logic [31:0] obs_err(input int s);  return s ? 32'(err1) : 32'(err0); endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transmission order: A, B, OP; within a field MSB first (inst 0) or LSB first (inst 1).
    function automatic logic bit_of(input int s, input logic [15:0] a, input logic [15:0] b,
                                    input logic [7:0] op, input int i);
        int dw;
        int w;
        int k;
        logic [15:0] v;
        dw = dw_of(s);
        if (i < dw) begin
            v = a; w = dw; k = i;
        end else if (i < 2 * dw) begin
            v = b; w = dw; k = i - dw;
        end else begin
            v = {8'h00, op}; w = ow_of(s); k = i - 2 * dw;
        end
        return s ? v[k] : v[w - 1 - k];
    endfunction

    task automatic check_committed(input int s, input string tag);
        check({tag, "_a"}, obs_a(s), 32'(exp_a[s]));
        check({tag, "_b"}, obs_b(s), 32'(exp_b[s]));
        check({tag, "_op"}, obs_op(s), 32'(exp_op[s]));
        check({tag, "_cnt"}, obs_cnt(s), 32'(exp_cnt[s]));
    endtask

    task automatic clear_inputs(input int s);
        start[s] = 1'b0; bitv[s] = 1'b0; valid[s] = 1'b0; abort[s] = 1'b0; ack[s] = 1'b0;
    endtask

    // One frame: gap of idle cycles before each bit, optional long stall before bit
    // stall_at, optional abort together with bit abort_at. done=1 if it committed.
    task automatic send_frame(input int s, input logic [15:0] a_in, input logic [15:0] b_in,
                              input logic [7:0] op_in, input int gap_lo, input int gap_hi,
                              input int stall_at, input int stall_len, input int abort_at,
                              output logic done);
        int n;
        int gap;
        logic [15:0] a;
        logic [15:0] b;
        logic [7:0]  op;
        a  = (s != 0) ? a_in : (a_in & 16'h00FF);
        b  = (s != 0) ? b_in : (b_in & 16'h00FF);
        op = op_in & 8'((1 << ow_of(s)) - 1);
        n  = 2 * dw_of(s) + ow_of(s);
        done = 1'b0;
        start[s] = 1'b1; valid[s] = 1'b1; bitv[s] = 1'b1;
        tick();
        start[s] = 1'b0; valid[s] = 1'b0;
        check("start_busy", obs_busy(s), 32'd1);
        for (int i = 0; i < n; i++) begin
            gap = (i == stall_at) ? stall_len : int'($urandom_range(gap_hi, gap_lo));
            for (int g = 0; g < gap; g++) begin
                valid[s] = 1'b0; bitv[s] = 1'($urandom);
                tick();
                if (g == TMO - 1) begin
                    check("tmo_pulse", obs_err(s), 32'd1);
                    check("tmo_busy", obs_busy(s), 32'd0);
                    tick();
                    check("tmo_pulse_end", obs_err(s), 32'd0);
                    check("tmo_fv", obs_fv(s), 32'd0);
                    check_committed(s, "tmo");
                    return;
                end
                check("gap_err", obs_err(s), 32'd0);
            end
            valid[s] = 1'b1;
            bitv[s]  = bit_of(s, a, b, op, i);
            abort[s] = (i == abort_at);
            tick();
            valid[s] = 1'b0; abort[s] = 1'b0;
            if (i == abort_at) begin
                check("abort_busy", obs_busy(s), 32'd0);
                check("abort_err", obs_err(s), 32'd0);
                check("abort_fv", obs_fv(s), 32'd0);
                check_committed(s, "abort");
                return;
            end
            if (i < n - 1) check("load_fv", obs_fv(s), 32'd0);
        end
        exp_a[s] = a; exp_b[s] = b; exp_op[s] = op; exp_cnt[s] = exp_cnt[s] + 8'd1;
        check("commit_fv", obs_fv(s), 32'd1);
        check("commit_busy", obs_busy(s), 32'd0);
        check("commit_err", obs_err(s), 32'd0);
        check_committed(s, "commit");
        done = 1'b1;
    endtask

    // Sit in HOLD with start/abort noise, then acknowledge.
    task automatic hold_and_ack(input int s, input int cycles);
        for (int h = 0; h < cycles; h++) begin
            start[s] = 1'($urandom); abort[s] = 1'($urandom);
            tick();
            check("hold_fv", obs_fv(s), 32'd1);
            check("hold_busy", obs_busy(s), 32'd0);
            check_committed(s, "hold");
        end
        start[s] = 1'b0; abort[s] = 1'b0; ack[s] = 1'b1;
        tick();
        ack[s] = 1'b0;
        check("ack_fv", obs_fv(s), 32'd0);
        check("ack_busy", obs_busy(s), 32'd0);
        check_committed(s, "ack");
    endtask

    task automatic pulse_reset(input string tag);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int s = 0; s < 2; s++) begin
            exp_a[s] = '0; exp_b[s] = '0; exp_op[s] = '0; exp_cnt[s] = '0;
            check({tag, "_fv"}, obs_fv(s), 32'd0);
            check({tag, "_busy"}, obs_busy(s), 32'd0);
            check({tag, "_err"}, obs_err(s), 32'd0);
            check_committed(s, tag);
        end
    endtask

    initial begin
        logic done;
        int   n;
        for (int s = 0; s < 2; s++) clear_inputs(s);
        rst_n = 1'b0;
        tick();
        pulse_reset("rst_init");

        // Directed frames on the MSB-first instance.
        send_frame(0, 16'hA5, 16'h3C, 8'h9, 0, 0, -1, 0, -1, done);
        check("t1_done", 32'(done), 32'd1);
        check("t1_a", obs_a(0), 32'hA5);
        hold_and_ack(0, 3);
        send_frame(0, 16'hA5, 16'h3C, 8'h9, 2, 2, -1, 0, -1, done);
        check("t2_done", 32'(done), 32'd1);
        hold_and_ack(0, 1);
        send_frame(0, 16'h5A, 16'hC3, 8'h6, 0, 1, 13, TMO, -1, done);
        check("t3_timeout", 32'(done), 32'd0);
        send_frame(0, 16'h5A, 16'hC3, 8'h6, 0, 1, 13, TMO - 1, -1, done);
        check("t3_edge_commit", 32'(done), 32'd1);
        hold_and_ack(0, 0);
        send_frame(0, 16'h11, 16'h22, 8'h3, 0, 1, -1, 0, 18, done);
        check("t4_aborted", 32'(done), 32'd0);
        send_frame(0, 16'h77, 16'h88, 8'hE, 0, 1, -1, 0, -1, done);
        check("t4_after_abort", 32'(done), 32'd1);
        hold_and_ack(0, 2);

        // Reset in the middle of LOAD_B, then in HOLD.
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        for (int i = 0; i < 11; i++) begin
            valid[0] = 1'b1; bitv[0] = 1'($urandom);
            tick();
        end
        valid[0] = 1'b0;
        pulse_reset("rst_loadb");
        send_frame(0, 16'hF0, 16'h0F, 8'h5, 0, 0, -1, 0, -1, done);
        check("t5_pre_hold", 32'(done), 32'd1);
        pulse_reset("rst_hold");

        // Random frames with occasional long stalls and aborts.
        for (int k = 0; k < 24; k++) begin
            int s_at;
            int ab;
            s_at = ($urandom_range(3, 0) == 0) ? int'($urandom_range(19, 0)) : -1;
            ab   = ($urandom_range(4, 0) == 0) ? int'($urandom_range(19, 0)) : -1;
            send_frame(0, 16'($urandom), 16'($urandom), 8'($urandom), 0, TMO - 1,
                       s_at, int'($urandom_range(TMO + 2, TMO - 2)), ab, done);
            if (done) hold_and_ack(0, int'($urandom_range(2, 0)));
        end

        // LSB-first wide instance, then enough frames to wrap the counter.
        send_frame(1, 16'h1234, 16'hBEEF, 8'h2A, 0, 2, -1, 0, -1, done);
        check("t6_done", 32'(done), 32'd1);
        check("t6_a", obs_a(1), 32'h1234);
        check("t6_b", obs_b(1), 32'hBEEF);
        check("t6_op", obs_op(1), 32'h2A);
        hold_and_ack(1, 1);
        n = 1;
        while (n < 256) begin
            send_frame(1, 16'($urandom), 16'($urandom), 8'($urandom), 0, 0, -1, 0, -1, done);
            if (done) begin
                n++;
                hold_and_ack(1, 0);
            end
        end
        check("t6_wrap", obs_cnt(1), 32'd0);
        check("t6_inst0_cnt", obs_cnt(0), 32'(exp_cnt[0]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

endmodule
